// File: rtl/spatz_pkg.sv
// Shared Spatz types: VRF address/data plus the read-streamer command, beat and state types.
package spatz_pkg;

    typedef struct packed {
        logic [4:0] vreg;
        logic [2:0] bank;
    } vreg_addr_t;

    typedef logic [31:0] vreg_data_t;

    // Command length field is sized for the widest streamer instance (LenWidth <= 16).
    localparam int unsigned VrfStreamLenW = 16;

    typedef struct packed {
        vreg_addr_t               addr;
        logic [VrfStreamLenW-1:0] len;
    } vrf_stream_cmd_t;

    typedef struct packed {
        vreg_data_t data;
        logic       last;
    } vrf_stream_beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } vrf_stream_state_e;

endpackage

// File: rtl/spatz_vrf_stream_fifo.sv
// Small operand FIFO for the VRF read streamer; registered head, push/pop in the same cycle allowed.
module spatz_vrf_stream_fifo
    import spatz_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  vrf_stream_beat_t beat_i,
    input  logic             pop_i,
    output vrf_stream_beat_t beat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    vrf_stream_beat_t  mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic              push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign beat_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= beat_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + CntW'(1);
            else if (!push_ok && pop_ok) cnt_q <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/spatz_vrf_rd_streamer.sv
// Streams a run of VRF words from one read port to an operand consumer via a small FIFO.
// Optional stall counter output enabled by defining SPATZ_VRF_STREAMER_PERF_EN.
module spatz_vrf_rd_streamer
    import spatz_pkg::*;
#(
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned LenWidth  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  vreg_addr_t          cmd_addr_i,
    input  logic [LenWidth-1:0] cmd_len_i,
    output logic                re_o,
    output vreg_addr_t          raddr_o,
    input  vreg_data_t          rdata_i,
    input  logic                rvalid_i,
    output vreg_data_t          data_o,
    output logic                data_last_o,
    output logic                data_valid_o,
    input  logic                data_ready_i,
    output logic                busy_o
`ifdef SPATZ_VRF_STREAMER_PERF_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    localparam int unsigned AddrW = $bits(vreg_addr_t);
    localparam int unsigned CntW  = $clog2(FifoDepth + 1);

    vrf_stream_state_e state_q, state_d;
    vrf_stream_cmd_t   cmd_q, cmd_d;
    vrf_stream_beat_t  push_beat, head_beat;
    logic              push, cmd_acc;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_cnt;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_ready_o = 1'b0;
        re_o        = 1'b0;
        cmd_acc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    cmd_acc = 1'b1;
                    if (cmd_len_i != '0) begin
                        cmd_d.addr = cmd_addr_i;
                        cmd_d.len  = VrfStreamLenW'(cmd_len_i);
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Registered occupancy only: keeps data_ready_i off the re_o path.
                re_o = ~fifo_full;
                if (re_o && rvalid_i) begin
                    cmd_d.addr = vreg_addr_t'(AddrW'(cmd_q.addr) + AddrW'(1));
                    cmd_d.len  = cmd_q.len - VrfStreamLenW'(1);
                    if (cmd_q.len == VrfStreamLenW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    assign push           = re_o & rvalid_i;
    assign push_beat.data = rdata_i;
    assign push_beat.last = (cmd_q.len == VrfStreamLenW'(1));

    spatz_vrf_stream_fifo #(
        .Depth (FifoDepth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .beat_i  (push_beat),
        .pop_i   (data_ready_i),
        .beat_o  (head_beat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign raddr_o      = cmd_q.addr;
    assign busy_o       = (state_q != IDLE);
    assign data_valid_o = ~fifo_empty;
    assign data_o       = head_beat.data;
    assign data_last_o  = head_beat.last & ~fifo_empty;

`ifdef SPATZ_VRF_STREAMER_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                 stall_q <= '0;
        else if (cmd_acc)                            stall_q <= '0;
        else if (re_o && !rvalid_i && stall_q != '1) stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt_o = stall_q;
`else
    logic unused_acc;
    assign unused_acc = cmd_acc;
`endif

endmodule

// File: tb/tb_spatz_vrf_rd_streamer.sv
// Directed table-driven bench for spatz_vrf_rd_streamer, plus hand sequences for len=0 and mid-command reset.
module tb_spatz_vrf_rd_streamer;
    import spatz_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    vreg_addr_t cmd_addr;
    logic [7:0] cmd_len;
    logic       re;
    vreg_addr_t raddr;
    vreg_data_t rdata;
    logic       rvalid;
    vreg_data_t data;
    logic       data_last, data_valid, data_ready, busy;
`ifdef SPATZ_VRF_STREAMER_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spatz_vrf_rd_streamer #(.FifoDepth(2), .LenWidth(8)) dut (
`ifdef SPATZ_VRF_STREAMER_PERF_EN
        .stall_cnt_o  (stall_cnt),
`endif
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .re_o         (re),
        .raddr_o      (raddr),
        .rdata_i      (rdata),
        .rvalid_i     (rvalid),
        .data_o       (data),
        .data_last_o  (data_last),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .busy_o       (busy)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  len;
        logic [15:0] rv_pat;     // bit r = rvalid on the r-th cycle re_o is high
        logic [15:0] rdy_pat;    // bit c = data_ready on cycle c after the handshake
        int          exp_grants;
        int          exp_early;  // grants before data_ready is first seen high
        int          exp_stalls;
        logic [7:0]  exp_last_addr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_cmd(input logic [7:0] a, input logic [7:0] l);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = vreg_addr_t'(a);
        cmd_len   = l;
        #1 chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int r = 0, grants = 0, beats = 0, early = 0;
        int last_g = -1, idle_c = -1;
        bit rdy_seen = 0, done = 0, rv, rdy;
        logic [7:0] a, exp_a, last_a;
        start_cmd(v.addr, v.len);
        last_a = '0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (beats == int'(v.len) && !busy) begin
                done   = 1;
                idle_c = cyc;
            end else begin
                rdy = (cyc < 16) ? v.rdy_pat[cyc] : 1'b1;
                if (rdy) rdy_seen = 1;
                a = raddr;
                if (cyc == 0) chk($sformatf("v%0d_first_req_latency", id), 32'(re), 32'd1);
                if (re) begin
                    rv = (r < 16) ? v.rv_pat[r] : 1'b1;
                    r++;
                    exp_a = v.addr + 8'(grants);
                    chk($sformatf("v%0d_raddr_req%0d", id, r), 32'(a), 32'(exp_a));
                end else begin
                    rv = 1'b1;  // stray grant with no request must be ignored
                end
                rvalid     = rv;
                rdata      = re ? {24'hD00000, a} : 32'hBAD0_0000;
                data_ready = rdy;
                if (re && rv) begin
                    grants++;
                    if (!rdy_seen) early++;
                    last_g = cyc;
                    last_a = a;
                end
                if (data_valid && rdy) begin
                    exp_a = v.addr + 8'(beats);
                    chk($sformatf("v%0d_beat%0d_data", id, beats), data, {24'hD00000, exp_a});
                    chk($sformatf("v%0d_beat%0d_last", id, beats), 32'(data_last),
                        32'(beats == int'(v.len) - 1));
                    beats++;
                end
            end
        end
        rvalid     = 1'b0;
        data_ready = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL v%0d_timeout: got beats %0d expected %0d", id, beats, v.len);
        end
        chk($sformatf("v%0d_grants", id), 32'(grants), 32'(v.exp_grants));
        chk($sformatf("v%0d_beats", id), 32'(beats), 32'(v.len));
        chk($sformatf("v%0d_early_grants", id), 32'(early), 32'(v.exp_early));
        chk($sformatf("v%0d_last_grant_addr", id), 32'(last_a), 32'(v.exp_last_addr));
        chk($sformatf("v%0d_idle_after_last_grant", id), 32'(idle_c - last_g), 32'd3);
        chk($sformatf("v%0d_cmd_ready_after", id), 32'(cmd_ready), 32'd1);
`ifdef SPATZ_VRF_STREAMER_PERF_EN
        chk($sformatf("v%0d_stall_cnt", id), stall_cnt, 32'(v.exp_stalls));
`endif
    endtask

    initial begin
        vecs[0] = '{8'h10, 8'd4, 16'hFFFF, 16'hFFFF, 4, 0, 0, 8'h13};
        vecs[1] = '{8'h20, 8'd4, 16'h0069, 16'hFFFF, 4, 0, 3, 8'h23};
        vecs[2] = '{8'hFF, 8'd2, 16'hFFFF, 16'hFFFF, 2, 0, 0, 8'h00};
        vecs[3] = '{8'h40, 8'd5, 16'hFFFF, 16'hFFC0, 5, 2, 0, 8'h44};
        vecs[4] = '{8'h05, 8'd1, 16'hFFFF, 16'hFFFF, 1, 0, 0, 8'h05};
        vecs[5] = '{8'h30, 8'd3, 16'hFFFF, 16'hFFFF, 3, 0, 0, 8'h32};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        rdata = '0; rvalid = 1'b0; data_ready = 1'b0;
        #2;
        chk("rst_re", 32'(re), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_data_last", 32'(data_last), 32'd0);
        #20 rst_n = 1'b1;

        // Zero-length command is swallowed without leaving IDLE.
        start_cmd(8'h55, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("len0_re_c%0d", i), 32'(re), 32'd0);
            chk($sformatf("len0_busy_c%0d", i), 32'(busy), 32'd0);
            chk($sformatf("len0_cmd_ready_c%0d", i), 32'(cmd_ready), 32'd1);
        end

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Reset after two of six grants, then a fresh command from its own base.
        start_cmd(8'h80, 8'd6);
        rvalid = 1'b1; data_ready = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rstmid_req0", 32'(re), 32'd1);
        @(negedge clk);
        chk("rstmid_req1", 32'(re), 32'd1);
        @(negedge clk);
        rvalid = 1'b0; data_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_re", 32'(re), 32'd0);
        chk("rstmid_data_valid", 32'(data_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(5, vecs[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
